// File: rtl/servo_pwm_slew.sv
// Hobby-servo PWM generator with per-frame slew limiting.
// One-entry target holding register with valid/ready handshake.
module servo_pwm_slew #(
  parameter int unsigned PERIOD_TICKS = 20000,
  parameter int unsigned PW_MIN       = 1000,
  parameter int unsigned PW_STEP      = 4,
  parameter int unsigned SLEW         = 2,
  parameter int unsigned POS_INIT     = 128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [7:0] tgt_data,
  input  logic       tgt_valid,
  output logic       tgt_ready,
  output logic       pwm,
  output logic       frame_start,
  output logic       busy
);

  localparam int unsigned CW = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;
  localparam logic [CW-1:0] LAST   = CW'(PERIOD_TICKS - 1);
  localparam logic [7:0]    POS0   = 8'(POS_INIT);
  localparam logic [15:0]   PWMIN  = 16'(PW_MIN);
  localparam logic [15:0]   PWSTEP = 16'(PW_STEP);
  localparam logic [15:0]   PW0    = 16'(PW_MIN + POS_INIT * PW_STEP);
  localparam logic [8:0]    SLEW9  = 9'(SLEW);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc;
  logic [7:0]    pos_q;
  logic [7:0]    pos_d;
  logic [7:0]    tgt_q;
  logic [7:0]    pend_q;
  logic          pend_v_q;
  logic [15:0]   pw_q;
  logic [15:0]   pw_d;
  logic          pwm_q;
  logic          fs_q;
  logic          boundary;
  logic [8:0]    diff;
  logic [7:0]    step;

  assign boundary    = tick & (cnt_q == LAST);
  assign cnt_inc     = cnt_q + 1'b1;
  assign tgt_ready   = ~pend_v_q;
  assign busy        = pend_v_q | (pos_q != tgt_q);
  assign pwm         = pwm_q;
  assign frame_start = fs_q;

  // Slew-limited next position toward the active target, no overshoot.
  always_comb begin
    diff  = 9'd0;
    step  = 8'd0;
    pos_d = pos_q;
    if (tgt_q > pos_q) begin
      diff  = {1'b0, tgt_q} - {1'b0, pos_q};
      step  = (diff < SLEW9) ? diff[7:0] : SLEW9[7:0];
      pos_d = pos_q + step;
    end else if (tgt_q < pos_q) begin
      diff  = {1'b0, pos_q} - {1'b0, tgt_q};
      step  = (diff < SLEW9) ? diff[7:0] : SLEW9[7:0];
      pos_d = pos_q - step;
    end
    pw_d = PWMIN + 16'(pos_d) * PWSTEP;
  end

  // Holding register: accept when empty, hand over to target on boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= 8'd0;
      pend_v_q <= 1'b0;
      tgt_q    <= POS0;
    end else if (boundary && pend_v_q) begin
      tgt_q    <= pend_q;
      pend_v_q <= 1'b0;
    end else if (tgt_valid && !pend_v_q) begin
      pend_q   <= tgt_data;
      pend_v_q <= 1'b1;
    end
  end

  // Frame counter, slew step and registered pulse output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= LAST;
      pos_q <= POS0;
      pw_q  <= PW0;
      pwm_q <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      fs_q <= 1'b0;
      if (boundary) begin
        cnt_q <= '0;
        pos_q <= pos_d;
        pw_q  <= pw_d;
        pwm_q <= 1'b1;
        fs_q  <= 1'b1;
      end else if (tick) begin
        cnt_q <= cnt_inc;
        pwm_q <= (16'(cnt_inc) < pw_q);
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_slew.sv
// Directed self-checking bench for servo_pwm_slew.
// Frame widths are counted in clk samples with tick=1 every cycle.
module tb_servo_pwm_slew;

  localparam int PT = 400;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b1;
  logic [7:0] tgt_data = 8'd0;
  logic       tgt_valid = 1'b0;
  logic       tgt_ready;
  logic       pwm;
  logic       frame_start;
  logic       busy;

  int checks = 0;
  int errors = 0;

  servo_pwm_slew #(
    .PERIOD_TICKS(400),
    .PW_MIN(20),
    .PW_STEP(1),
    .SLEW(8),
    .POS_INIT(128)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tick(tick),
    .tgt_data(tgt_data),
    .tgt_valid(tgt_valid),
    .tgt_ready(tgt_ready),
    .pwm(pwm),
    .frame_start(frame_start),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Wait for a frame_start sample, then count pwm-high samples over one frame.
  task automatic get_frame(output int w, output logic b,
                           output logic r, output logic ok);
    int n;
    n = 0;
    ok = 1'b1;
    w = -1;
    b = 1'bx;
    r = 1'bx;
    while (frame_start !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      ok = 1'b0;
    end else begin
      b = busy;
      r = tgt_ready;
      w = 0;
      for (int i = 0; i < PT; i++) begin
        if (i > 0 && frame_start !== 1'b0) ok = 1'b0;
        if (pwm === 1'b1) w++;
        @(negedge clk);
      end
      if (frame_start !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic frame_chk(input string nm, input int exp_w,
                           input logic exp_b, input logic exp_r);
    int w;
    logic b, r, ok;
    get_frame(w, b, r, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s period: frame_start spacing not %0d", nm, PT);
    end
    checks++;
    if (w !== exp_w) begin
      errors++;
      $display("FAIL %s width: got %0d expected %0d", nm, w, exp_w);
    end
    checks++;
    if (b !== exp_b || r !== exp_r) begin
      errors++;
      $display("FAIL %s busy/ready: got %b/%b expected %b/%b",
               nm, b, r, exp_b, exp_r);
    end
  endtask

  task automatic send(input logic [7:0] d);
    tgt_data = d;
    tgt_valid = 1'b1;
    @(negedge clk);
    tgt_valid = 1'b0;
    checks++;
    if (tgt_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL accept %0d: ready/busy got %b/%b expected 0/1",
               d, tgt_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (pwm !== 1'b0 || frame_start !== 1'b0 ||
        tgt_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: pwm/fs/ready/busy got %b%b%b%b expected 0010",
               pwm, frame_start, tgt_ready, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (pwm !== 1'b1 || frame_start !== 1'b1) begin
      errors++;
      $display("FAIL first_edge: pwm/fs got %b%b expected 11",
               pwm, frame_start);
    end
  endtask

  task automatic test_idle();
    for (int k = 0; k < 3; k++) frame_chk("idle", 148, 1'b0, 1'b1);
  endtask

  task automatic test_ramp();
    send(8'd200);
    frame_chk("ramp_xfer", 148, 1'b1, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      int e;
      e = (k <= 9) ? 148 + 8 * k : 220;
      frame_chk("ramp", e, (k < 9), 1'b1);
    end
  endtask

  task automatic test_small_step();
    send(8'd197);
    frame_chk("small_xfer", 220, 1'b1, 1'b1);
    frame_chk("small_step", 217, 1'b0, 1'b1);
    frame_chk("small_hold", 217, 1'b0, 1'b1);
  endtask

  task automatic test_reject();
    send(8'd10);
    tgt_data = 8'd250;
    tgt_valid = 1'b1;
    repeat (3) @(negedge clk);
    tgt_valid = 1'b0;
    checks++;
    if (tgt_ready !== 1'b0) begin
      errors++;
      $display("FAIL reject_ready: got %b expected 0", tgt_ready);
    end
    frame_chk("down_xfer", 217, 1'b1, 1'b1);
    for (int k = 1; k <= 26; k++) begin
      int e;
      e = (k <= 23) ? 217 - 8 * k : 30;
      frame_chk("down", e, (k < 24), 1'b1);
    end
  endtask

  task automatic test_freeze();
    int hi;
    int ticked;
    int n;
    logic frz_ok;
    hi = 0;
    ticked = 0;
    n = 0;
    frz_ok = 1'b1;
    while (frame_start !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      if (pwm === 1'b1) hi++;
      ticked++;
      @(negedge clk);
    end
    tick = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (pwm !== 1'b1 || frame_start !== 1'b0) frz_ok = 1'b0;
      @(negedge clk);
    end
    tick = 1'b1;
    checks++;
    if (!frz_ok) begin
      errors++;
      $display("FAIL freeze: pwm not held high / frame_start seen");
    end
    n = 0;
    while (frame_start !== 1'b1 && n < 1000) begin
      if (pwm === 1'b1) hi++;
      ticked++;
      n++;
      @(negedge clk);
    end
    checks++;
    if (hi !== 30 || ticked !== PT) begin
      errors++;
      $display("FAIL freeze_resume: high %0d len %0d expected 30 %0d",
               hi, ticked, PT);
    end
  endtask

  task automatic test_reset_mid();
    send(8'd100);
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (pwm !== 1'b0 || tgt_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: pwm/ready/busy got %b%b%b expected 010",
               pwm, tgt_ready, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) frame_chk("post_reset", 148, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_ramp();
    test_small_step();
    test_reject();
    test_freeze();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/servo_pwm_slew.md
Name: servo_pwm_slew

Overview:
- Downstream consumer of the prescaler tick in the robot-arm timing chain. Converts a commanded joint position into a standard hobby-servo PWM waveform.
- Limits position change per PWM frame (slew rate) so the arm never jumps to a new target.
- One instance per joint. All instances share the same `tick` enable and `clk`.

Parameters:
- PERIOD_TICKS, 20000, ticks per PWM frame (20 ms at a 1 µs tick); must be ≥ 2.
- PW_MIN, 1000, pulse width in ticks at position 0.
- PW_STEP, 4, extra pulse-width ticks per position unit; PW_MIN + 255*PW_STEP must be < PERIOD_TICKS.
- SLEW, 2, maximum position units moved per frame; 1..255.
- POS_INIT, 128, position and target value after reset.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tick  input  1  one-clk-wide enable from the prescaler; all frame timing advances only on clk edges where tick=1.
- tgt_data  input  8  requested position 0..255.
- tgt_valid  input  1  tgt_data is valid this cycle.
- tgt_ready  output  1  block can accept a target this cycle.
- pwm  output  1  servo pulse output, registered.
- frame_start  output  1  registered; high for one clk in the cycle pwm starts a new frame.
- busy  output  1  high while a target is pending or pos ≠ tgt_reg.

Behaviour:
- Internal state:
  - cnt: frame counter, width clog2(PERIOD_TICKS).
  - pos[7:0]: current position.
  - tgt_reg[7:0]: active target.
  - pend[7:0] and pend_v: one-entry holding register.
  - pw[15:0]: active pulse width.
- Reset (async, immediate): cnt=PERIOD_TICKS-1, pos=tgt_reg=POS_INIT, pend_v=0, pw=PW_MIN+POS_INIT*PW_STEP, pwm=0, frame_start=0. Because cnt starts at PERIOD_TICKS-1, the first tick after reset release is a frame boundary.
- Handshake:
  - tgt_ready = ~pend_v (combinational from register).
  - Accept occurs when tgt_valid & tgt_ready: pend<=tgt_data, pend_v<=1.
  - tgt_valid while tgt_ready=0 is ignored; pend is unchanged.
  - tgt_valid is not required to be held.
- Tick handling:
  - No tick: cnt, pos, tgt_reg, pw and pwm all hold; frame_start=0.
  - Tick, not a boundary (cnt<PERIOD_TICKS-1): cnt<=cnt+1; pwm<=(cnt+1 < pw).
- Boundary = tick & cnt==PERIOD_TICKS-1. On the boundary, in the same clk edge:
  - Slew step, using the old tgt_reg: if tgt_reg>pos, pos_n = pos + min(SLEW, tgt_reg-pos). If tgt_reg<pos, pos_n = pos - min(SLEW, pos-tgt_reg). Otherwise pos_n = pos. No overshoot and no 8-bit wrap; compute the step in 9 bits.
  - pos<=pos_n; pw<=PW_MIN+pos_n*PW_STEP, computed 16-bit unsigned.
  - If pend_v: tgt_reg<=pend, pend_v<=0. The new target influences pos starting at the next boundary.
  - cnt<=0; pwm<=1; frame_start<=1.
- frame_start is 0 on all other cycles.
- Resulting waveform: pwm is high for exactly pw ticks, then low for PERIOD_TICKS-pw ticks. pw is constant within a frame.
- Accept on a boundary cycle: if pend_v=0 at that edge, the data lands in pend and is transferred at the following boundary.
- busy = pend_v | (pos≠tgt_reg), combinational from registers.
- Reset asserted mid-frame or mid-handshake: pwm drops asynchronously and any pending target is discarded.

Test Plan:
Bench parameters: PERIOD_TICKS=400, PW_MIN=20, PW_STEP=1, SLEW=8, POS_INIT=128; tick=1 every clk unless stated.
- Release reset, no targets → frame_start every 400 clks; pwm high 148 clks per frame, first rising edge on the first clk after release; busy=0; tgt_ready=1.
- Drive tgt_data=200 for one cycle → tgt_ready=0 next cycle and back to 1 after the next boundary. Successive frame widths 148, 148, 156, 164, …, 220, then stable at 220. busy falls at the boundary where pos reaches 200.
- Starting from pos=200, send target 197 → after the transfer frame, the next frame width is exactly 217 (single 3-unit step, no overshoot); busy then clears.
- Send target 10, then tgt_valid=1 with data 250 while tgt_ready=0 → 250 ignored; pos ramps down by 8 per frame to 10 (width 30 final); 250 never appears.
- tick held 0 for 1000 clks mid-pulse → pwm, cnt and pos frozen; the pulse resumes with the same remaining length when tick returns.
- Assert rst_n=0 mid-pulse with a target pending → pwm=0 immediately without a clk edge; after release tgt_ready=1, width back to 148, pending target lost.
